// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types and width helpers for the dual-port block RAM
package bram_pkg;

   // Which word a read sees when the other port writes the same address in the same cycle
   typedef enum logic {RDW_OLD = 1'b0, RDW_NEW = 1'b1} rdw_mode_e;

   // Clear sequencer states
   typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} clr_state_e;

   // Address width; a one-word memory still gets a one-bit address
   function automatic int calc_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Number of byte lanes per word
   function automatic int calc_bw(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// rtl/bram_rd_pipe.sv - per-port read output stage with hold, valid and optional output register
module bram_rd_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter int OUT_REG    = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  in_range,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  valid
);

   logic [DATA_WIDTH-1:0] s1_q;
   logic                  s1_v;

   // First stage: capture the array word (zero when out of range) and hold it between reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s1_v <= 1'b0;
      end else begin
         s1_v <= req;
         if (req) begin
            s1_q <= in_range ? rdata : '0;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_WIDTH-1:0] s2_q;
         logic                  s2_v;

         // Optional second stage: forward only fresh data so q keeps holding the last read
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s2_q <= '0;
               s2_v <= 1'b0;
            end else begin
               s2_v <= s1_v;
               if (s1_v) begin
                  s2_q <= s1_q;
               end
            end
         end

         assign q     = s2_q;
         assign valid = s2_v;
      end else begin : g_noreg
         assign q     = s1_q;
         assign valid = s1_v;
      end
   endgenerate

endmodule

// File: rtl/bram_dp.sv
// rtl/bram_dp.sv - true dual-port byte-enabled block RAM with clear sequencer
module bram_dp
   import bram_pkg::*;
#(
   parameter int        ADDRESS_DEPTH = 4096,
   parameter int        DATA_WIDTH    = 16,
   parameter int        BYTE_WIDTH    = 8,
   parameter int        OUT_REG       = 0,
   parameter rdw_mode_e RDW_MODE      = RDW_OLD,
   localparam int       AW            = calc_aw(ADDRESS_DEPTH),
   localparam int       BW            = calc_bw(DATA_WIDTH, BYTE_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_req,
   output logic                  busy,
   output logic                  collision,
   input  logic                  a_en,
   input  logic                  a_wr,
   input  logic [BW-1:0]         a_be,
   input  logic [AW-1:0]         a_addr,
   input  logic [DATA_WIDTH-1:0] a_data,
   output logic [DATA_WIDTH-1:0] a_q,
   output logic                  a_valid,
   input  logic                  b_en,
   input  logic                  b_wr,
   input  logic [BW-1:0]         b_be,
   input  logic [AW-1:0]         b_addr,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic [DATA_WIDTH-1:0] b_q,
   output logic                  b_valid
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(ADDRESS_DEPTH - 1);
   localparam logic [AW:0]   DEPTH_V   = (AW + 1)'(ADDRESS_DEPTH);

   logic [DATA_WIDTH-1:0] mem [ADDRESS_DEPTH];

   clr_state_e            state, state_nxt;
   logic [AW-1:0]         clr_cnt, clr_cnt_nxt;

   logic                  a_in, b_in;
   logic                  a_we, b_we, a_re, b_re;
   logic [AW-1:0]         a_idx, b_idx;
   logic [DATA_WIDTH-1:0] a_old, b_old, a_rd_new, b_rd_new, a_rdata, b_rdata;

   assign busy = (state == CLEAR);

   // Port qualification: requests are dropped while sweeping, writes also when out of range
   assign a_in  = ({1'b0, a_addr} < DEPTH_V);
   assign b_in  = ({1'b0, b_addr} < DEPTH_V);
   assign a_we  = ~busy & a_en & a_wr & a_in;
   assign b_we  = ~busy & b_en & b_wr & b_in;
   assign a_re  = ~busy & a_en & ~a_wr;
   assign b_re  = ~busy & b_en & ~b_wr;
   assign a_idx = a_in ? a_addr : '0;
   assign b_idx = b_in ? b_addr : '0;
   assign a_old = mem[a_idx];
   assign b_old = mem[b_idx];

   // Clear sequencer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   // Clear sequencer: sweep every word once, then wait for a new request
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         CLEAR: begin
            if (clr_cnt == LAST_ADDR) begin
               state_nxt = IDLE;
            end else begin
               clr_cnt_nxt = clr_cnt + 1'b1;
            end
         end
         IDLE: begin
            if (clr_req) begin
               state_nxt   = CLEAR;
               clr_cnt_nxt = '0;
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   // Read-through view: a read sees the other port's bytes merged in when it writes the same word
   always_comb begin
      a_rd_new = a_old;
      b_rd_new = b_old;
      for (int i = 0; i < BW; i++) begin
         if (b_we && b_be[i] && (b_addr == a_addr)) begin
            a_rd_new[i*BYTE_WIDTH +: BYTE_WIDTH] = b_data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
         if (a_we && a_be[i] && (a_addr == b_addr)) begin
            b_rd_new[i*BYTE_WIDTH +: BYTE_WIDTH] = a_data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   assign a_rdata = (RDW_MODE == RDW_NEW) ? a_rd_new : a_old;
   assign b_rdata = (RDW_MODE == RDW_NEW) ? b_rd_new : b_old;

   // Storage update: sweep zeroes one word per cycle; otherwise B lanes first so A wins overlaps
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[clr_cnt] <= '0;
      end else begin
         for (int i = 0; i < BW; i++) begin
            if (b_we && b_be[i]) begin
               mem[b_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
         for (int i = 0; i < BW; i++) begin
            if (a_we && a_be[i]) begin
               mem[a_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // Collision flag: both ports wrote overlapping byte lanes of one word last cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         collision <= 1'b0;
      end else begin
         collision <= a_we & b_we & (a_addr == b_addr) & (|(a_be & b_be));
      end
   end

   bram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_REG    (OUT_REG)
   ) u_a_pipe (
      .clk      (clk),
      .rst      (rst),
      .req      (a_re),
      .in_range (a_in),
      .rdata    (a_rdata),
      .q        (a_q),
      .valid    (a_valid)
   );

   bram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_REG    (OUT_REG)
   ) u_b_pipe (
      .clk      (clk),
      .rst      (rst),
      .req      (b_re),
      .in_range (b_in),
      .rdata    (b_rdata),
      .q        (b_q),
      .valid    (b_valid)
   );

endmodule

// File: tb/tb_bram_dp.sv
// tb/tb_bram_dp.sv - self-checking bench for bram_dp, two configurations side by side
module tb_bram_dp;
   import bram_pkg::*;

   logic        clk;
   logic        rst;
   logic        clr_req;
   logic        a_en, a_wr, b_en, b_wr;
   logic [1:0]  a_be, b_be;
   logic [3:0]  a_addr, b_addr;
   logic [15:0] a_data, b_data;

   logic        busy0, coll0, a_valid0, b_valid0;
   logic [15:0] a_q0, b_q0;
   logic        busy1, coll1, a_valid1, b_valid1;
   logic [15:0] a_q1, b_q1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Instance 0: 16 words, no output register, old data on cross-port read/write
   bram_dp #(.ADDRESS_DEPTH(16), .DATA_WIDTH(16), .BYTE_WIDTH(8), .OUT_REG(0), .RDW_MODE(RDW_OLD)) dut0 (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0), .collision(coll0),
      .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_data(a_data),
      .a_q(a_q0), .a_valid(a_valid0),
      .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_data(b_data),
      .b_q(b_q0), .b_valid(b_valid0));

   // Instance 1: 12 words (non power of two), output register, new data on cross-port read/write
   bram_dp #(.ADDRESS_DEPTH(12), .DATA_WIDTH(16), .BYTE_WIDTH(8), .OUT_REG(1), .RDW_MODE(RDW_NEW)) dut1 (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1), .collision(coll1),
      .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_data(a_data),
      .a_q(a_q1), .a_valid(a_valid1),
      .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_data(b_data),
      .b_q(b_q1), .b_valid(b_valid1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {int due; logic [15:0] d;} rd_t;

   logic [15:0] mm [2][16];
   int          left [2];
   logic [15:0] mq [2][2];
   logic        mcoll [2];
   rd_t         rq [4][$];

   function automatic int dep(input int k);  return (k == 0) ? 16 : 12; endfunction
   function automatic int odl(input int k);  return (k == 0) ? 0 : 1;   endfunction
   function automatic bit rnew(input int k); return (k == 1);           endfunction

   // Word x after this cycle's writes: B lanes first, then A lanes (A wins overlaps)
   function automatic logic [15:0] merged(input int k, input int x);
      logic [15:0] w;
      w = mm[k][x];
      if (b_en && b_wr && int'(b_addr) < dep(k) && int'(b_addr) == x)
         for (int i = 0; i < 2; i++) if (b_be[i]) w[i*8 +: 8] = b_data[i*8 +: 8];
      if (a_en && a_wr && int'(a_addr) < dep(k) && int'(a_addr) == x)
         for (int i = 0; i < 2; i++) if (a_be[i]) w[i*8 +: 8] = a_data[i*8 +: 8];
      return w;
   endfunction

   task automatic model_reset(input int k);
      left[k]  = dep(k);
      mcoll[k] = 1'b0;
      mq[k][0] = '0;
      mq[k][1] = '0;
      rq[k*2].delete();
      rq[k*2+1].delete();
      for (int j = 0; j < 16; j++) mm[k][j] = '0;
   endtask

   task automatic model_edge(input int k);
      int ai, bi;
      bit ain, bin, awe, bwe;
      logic [15:0] wa, wb;
      rd_t r;
      ai  = int'(a_addr);
      bi  = int'(b_addr);
      ain = ai < dep(k);
      bin = bi < dep(k);
      if (left[k] > 0) begin
         left[k]--;
         mcoll[k] = 1'b0;
      end else begin
         awe = a_en && a_wr && ain;
         bwe = b_en && b_wr && bin;
         if (a_en && !a_wr) begin
            r.due = cyc + 1 + odl(k);
            r.d   = !ain ? 16'h0 : (rnew(k) ? merged(k, ai) : mm[k][ai]);
            rq[k*2].push_back(r);
         end
         if (b_en && !b_wr) begin
            r.due = cyc + 1 + odl(k);
            r.d   = !bin ? 16'h0 : (rnew(k) ? merged(k, bi) : mm[k][bi]);
            rq[k*2+1].push_back(r);
         end
         mcoll[k] = awe && bwe && (ai == bi) && ((a_be & b_be) != 2'b00);
         wa = awe ? merged(k, ai) : 16'h0;
         wb = bwe ? merged(k, bi) : 16'h0;
         if (bwe) mm[k][bi] = wb;
         if (awe) mm[k][ai] = wa;
         if (clr_req) begin
            left[k] = dep(k);
            for (int j = 0; j < 16; j++) mm[k][j] = '0;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_port(input int k, input int p, input logic v, input logic [15:0] q);
      bit  ev;
      rd_t r;
      ev = (rq[k*2+p].size() > 0) && (rq[k*2+p][0].due == cyc);
      if (ev) begin
         r = rq[k*2+p].pop_front();
         mq[k][p] = r.d;
      end
      chk($sformatf("d%0d_%s_valid", k, p == 0 ? "a" : "b"), {31'd0, v}, {31'd0, ev});
      chk($sformatf("d%0d_%s_q", k, p == 0 ? "a" : "b"), {16'd0, q}, {16'd0, mq[k][p]});
   endtask

   task automatic check_all();
      chk("d0_busy", {31'd0, busy0}, {31'd0, left[0] > 0});
      chk("d1_busy", {31'd0, busy1}, {31'd0, left[1] > 0});
      chk("d0_collision", {31'd0, coll0}, {31'd0, mcoll[0]});
      chk("d1_collision", {31'd0, coll1}, {31'd0, mcoll[1]});
      chk_port(0, 0, a_valid0, a_q0);
      chk_port(0, 1, b_valid0, b_q0);
      chk_port(1, 0, a_valid1, a_q1);
      chk_port(1, 1, b_valid1, b_q1);
   endtask

   task automatic tick();
      if (rst) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_edge(0);
         model_edge(1);
      end
      @(posedge clk);
      #1;
      cyc++;
      check_all();
   endtask

   task automatic idle_in();
      a_en = 0; a_wr = 0; a_be = 0; a_addr = 0; a_data = 0;
      b_en = 0; b_wr = 0; b_be = 0; b_addr = 0; b_data = 0;
      clr_req = 0;
   endtask

   // Count busy cycles from now (one observation before the first edge) until both sweeps end
   task automatic count_sweep(input string tag);
      int bc0, bc1;
      bc0 = busy0 ? 1 : 0;
      bc1 = busy1 ? 1 : 0;
      for (int i = 0; i < 40 && (busy0 || busy1); i++) begin
         tick();
         if (busy0) bc0++;
         if (busy1) bc1++;
      end
      chk({tag, "_len_d0"}, bc0, 16);
      chk({tag, "_len_d1"}, bc1, 12);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic a_en, a_wr; logic [1:0] a_be; logic [3:0] a_addr; logic [15:0] a_data;
      logic b_en, b_wr; logic [1:0] b_be; logic [3:0] b_addr; logic [15:0] b_data;
      logic coll, ca, cb;
      logic [15:0] qa0, qb0, qa1, qb1;
   } vec_t;

   vec_t tbl [12];

   initial begin
      tbl[0]  = '{1,1,2'b01,4'd3, 16'hABCD, 0,0,2'b00,4'd0,16'h0000, 0,0,0, 16'h0,16'h0,16'h0,16'h0};
      tbl[1]  = '{1,0,2'b00,4'd3, 16'h0000, 0,0,2'b00,4'd0,16'h0000, 0,1,0, 16'h00CD,16'h0,16'h00CD,16'h0};
      tbl[2]  = '{1,1,2'b11,4'd5, 16'h1111, 1,1,2'b11,4'd5,16'h2222, 1,0,0, 16'h0,16'h0,16'h0,16'h0};
      tbl[3]  = '{1,0,2'b00,4'd5, 16'h0000, 0,0,2'b00,4'd0,16'h0000, 0,1,0, 16'h1111,16'h0,16'h1111,16'h0};
      tbl[4]  = '{1,1,2'b10,4'd5, 16'h1111, 1,1,2'b01,4'd5,16'h2222, 0,0,0, 16'h0,16'h0,16'h0,16'h0};
      tbl[5]  = '{0,0,2'b00,4'd0, 16'h0000, 1,0,2'b00,4'd5,16'h0000, 0,0,1, 16'h0,16'h1122,16'h0,16'h1122};
      tbl[6]  = '{1,1,2'b11,4'd7, 16'h0005, 0,0,2'b00,4'd0,16'h0000, 0,0,0, 16'h0,16'h0,16'h0,16'h0};
      tbl[7]  = '{1,1,2'b11,4'd7, 16'h0009, 1,0,2'b00,4'd7,16'h0000, 0,0,1, 16'h0,16'h0005,16'h0,16'h0009};
      tbl[8]  = '{1,1,2'b11,4'd13,16'h7777, 0,0,2'b00,4'd0,16'h0000, 0,0,0, 16'h0,16'h0,16'h0,16'h0};
      tbl[9]  = '{1,0,2'b00,4'd13,16'h0000, 0,0,2'b00,4'd0,16'h0000, 0,1,0, 16'h7777,16'h0,16'h0000,16'h0};
      tbl[10] = '{0,0,2'b00,4'd0, 16'h0000, 1,0,2'b00,4'd1,16'h0000, 0,0,1, 16'h0,16'h0000,16'h0,16'h0000};
      tbl[11] = '{1,0,2'b00,4'd11,16'h0000, 1,0,2'b00,4'd0,16'h0000, 0,1,1, 16'h0000,16'h0000,16'h0000,16'h0000};

      idle_in();
      rst = 1'b1;
      model_reset(0);
      model_reset(1);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_all();

      // Power-up sweep length, then every address reads back zero
      count_sweep("pwrup");
      for (int i = 0; i < 16; i++) begin
         a_en = 1; a_wr = 0; a_addr = 4'(i);
         b_en = 1; b_wr = 0; b_addr = 4'(15 - i);
         tick();
      end
      idle_in();
      tick();
      tick();

      // Directed vectors: instance 0 answers after one edge, instance 1 after two
      for (int v = 0; v < 12; v++) begin
         a_en = tbl[v].a_en; a_wr = tbl[v].a_wr; a_be = tbl[v].a_be;
         a_addr = tbl[v].a_addr; a_data = tbl[v].a_data;
         b_en = tbl[v].b_en; b_wr = tbl[v].b_wr; b_be = tbl[v].b_be;
         b_addr = tbl[v].b_addr; b_data = tbl[v].b_data;
         tick();
         chk($sformatf("vec%0d_coll_d0", v), {31'd0, coll0}, {31'd0, tbl[v].coll});
         chk($sformatf("vec%0d_coll_d1", v), {31'd0, coll1}, {31'd0, tbl[v].coll});
         if (tbl[v].ca) begin
            chk($sformatf("vec%0d_a_valid_d0", v), {31'd0, a_valid0}, 32'd1);
            chk($sformatf("vec%0d_a_q_d0", v), {16'd0, a_q0}, {16'd0, tbl[v].qa0});
         end
         if (tbl[v].cb) begin
            chk($sformatf("vec%0d_b_valid_d0", v), {31'd0, b_valid0}, 32'd1);
            chk($sformatf("vec%0d_b_q_d0", v), {16'd0, b_q0}, {16'd0, tbl[v].qb0});
         end
         idle_in();
         tick();
         if (tbl[v].ca) begin
            chk($sformatf("vec%0d_a_valid_d1", v), {31'd0, a_valid1}, 32'd1);
            chk($sformatf("vec%0d_a_q_d1", v), {16'd0, a_q1}, {16'd0, tbl[v].qa1});
         end
         if (tbl[v].cb) begin
            chk($sformatf("vec%0d_b_valid_d1", v), {31'd0, b_valid1}, 32'd1);
            chk($sformatf("vec%0d_b_q_d1", v), {16'd0, b_q1}, {16'd0, tbl[v].qb1});
         end
      end

      // Randomized traffic with occasional clear requests
      for (int n = 0; n < 600; n++) begin
         a_en = ($urandom % 4) != 0; a_wr = $urandom % 2; a_be = 2'($urandom);
         a_addr = (($urandom % 3) == 0) ? 4'($urandom % 4) : 4'($urandom);
         a_data = 16'($urandom);
         b_en = ($urandom % 4) != 0; b_wr = $urandom % 2; b_be = 2'($urandom);
         b_addr = (($urandom % 3) == 0) ? 4'($urandom % 4) : 4'($urandom);
         b_data = 16'($urandom);
         clr_req = ($urandom % 64) == 0;
         tick();
      end
      idle_in();
      for (int i = 0; i < 40 && (busy0 || busy1); i++) tick();
      chk("rand_settle_busy", {31'd0, busy0 | busy1}, 32'd0);

      // Clear request alongside a read, then reset when the sweep counter reaches 6
      a_en = 1; a_wr = 0; a_addr = 4'd3;
      clr_req = 1;
      tick();
      idle_in();
      for (int i = 0; i < 6; i++) tick();
      rst = 1'b1;
      model_reset(0);
      model_reset(1);
      #1;
      check_all();
      tick();
      rst = 1'b0;
      #1;
      count_sweep("restart");

      // Reset while instance 1 still has a read in its output register
      a_en = 1; a_wr = 0; a_addr = 4'd3;
      b_en = 1; b_wr = 0; b_addr = 4'd5;
      tick();
      idle_in();
      rst = 1'b1;
      model_reset(0);
      model_reset(1);
      #1;
      check_all();
      tick();
      rst = 1'b0;
      #1;
      count_sweep("midread");
      a_en = 1; a_wr = 0; a_addr = 4'd5;
      tick();
      idle_in();
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
